// File: rtl/led_blink_ctrl_pkg.sv
// Shared definitions for the LED blink controller: mode encodings,
// configuration field widths and a small helper used by RTL and bench alike.
package led_blink_ctrl_pkg;

    // Channel operating mode, also used as the per-channel state.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'd0;
    localparam mode_t MODE_ON    = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_BURST = 2'd3;

    // Width of the channel index field on the configuration port.
    localparam int CFG_CH_W = 4;
    // Width of the burst length field on the configuration port.
    localparam int BURST_W  = 8;

    // True for the modes that run off the shared tick (and report busy).
    function automatic logic mode_is_active(input mode_t m);
        return (m == MODE_BLINK) || (m == MODE_BURST);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration request channel of the LED blink controller: a single
// valid/ready handshake carrying channel index, mode, half-period and
// burst length.
interface led_blink_ctrl_if #(
    parameter int PER_W = 16
);
    import led_blink_ctrl_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_CH_W-1:0] cfg_ch;
    mode_t               cfg_mode;
    logic [PER_W-1:0]    cfg_half_period;
    logic [BURST_W-1:0]  cfg_burst_len;

    // Requester side.
    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_half_period,
        output cfg_burst_len,
        input  cfg_ready
    );

    // Controller side.
    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_half_period,
        input  cfg_burst_len,
        output cfg_ready
    );

endinterface

// File: rtl/led_chan.sv
// One LED channel: holds the mode, a tick counter for the half-period,
// the remaining burst count and the registered led/done outputs.
module led_chan
    import led_blink_ctrl_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               tick_i,
    input  logic               load_i,
    input  mode_t              mode_i,
    input  logic [PER_W-1:0]   half_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic               led_o,
    output logic               busy_o,
    output logic               done_o
);

    mode_t              mode_q, mode_d;
    logic [PER_W-1:0]   cnt_q,  cnt_d;
    logic [PER_W-1:0]   half_q, half_d;
    logic [BURST_W-1:0] rem_q,  rem_d;
    logic               led_q,  led_d;
    logic               done_q, done_d;

    logic               wrap;

    // The toggle point is the last tick of the half-period.
    assign wrap = (cnt_q == (half_q - PER_W'(1)));

    // Next-state: a load always wins over a tick arriving in the same cycle.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        rem_d  = rem_q;
        led_d  = led_q;
        done_d = 1'b0;

        if (load_i) begin
            cnt_d  = '0;
            // A zero half-period would never reach its terminal count.
            half_d = (half_i == '0) ? PER_W'(1) : half_i;
            rem_d  = (mode_i == MODE_BURST) ? burst_i : '0;
            case (mode_i)
                MODE_ON: begin
                    mode_d = MODE_ON;
                    led_d  = 1'b1;
                end
                MODE_BLINK: begin
                    mode_d = MODE_BLINK;
                    led_d  = 1'b1;
                end
                MODE_BURST: begin
                    if (burst_i == '0) begin
                        // An empty burst finishes immediately.
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        mode_d = MODE_BURST;
                        led_d  = 1'b1;
                    end
                end
                default: begin
                    mode_d = MODE_OFF;
                    led_d  = 1'b0;
                end
            endcase
        end else if (tick_i && mode_is_active(mode_q)) begin
            if (wrap) begin
                cnt_d = '0;
                led_d = !led_q;
                // Each falling toggle in a burst ends one on/off cycle.
                if ((mode_q == MODE_BURST) && led_q) begin
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) begin
                        mode_d = MODE_OFF;
                        done_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    // Channel state registers, cleared by the asynchronous reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
            half_q <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = mode_is_active(mode_q);
    assign done_o = done_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: a free-running prescaler produces a
// shared tick, the configuration handshake routes each request to one
// channel, and every channel runs independently in its own led_chan.
module led_blink_ctrl
    import led_blink_ctrl_pkg::*;
#(
    parameter int          CH_NUM   = 4,
    parameter logic [23:0] TICK_MAX = 24'd49_999,
    parameter int          PER_W    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    led_blink_ctrl_if.slave     cfg,
    output logic [CH_NUM-1:0]   led_out,
    output logic [CH_NUM-1:0]   busy,
    output logic [CH_NUM-1:0]   done
);

    logic [23:0] pre_q, pre_d;
    logic        ready_q, ready_d;
    logic        tick;
    logic        xfer;

    // One-cycle tick at the terminal count of the prescaler.
    assign tick = (pre_q == TICK_MAX);

    // Prescaler next count: wrap at the terminal count.
    always_comb begin
        pre_d = tick ? 24'd0 : (pre_q + 24'd1);
    end

    // Once out of reset the controller always accepts requests.
    assign ready_d = 1'b1;

    // Prescaler and ready flag; ready rises on the first edge after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_q   <= 24'd0;
            ready_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            ready_q <= ready_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign xfer          = cfg.cfg_valid && ready_q;

    // Requests addressed beyond CH_NUM match no channel and are dropped.
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
            logic load;

            assign load = xfer && (cfg.cfg_ch == CFG_CH_W'(gi));

            led_chan #(
                .PER_W (PER_W)
            ) u_chan (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .tick_i    (tick),
                .load_i    (load),
                .mode_i    (cfg.cfg_mode),
                .half_i    (cfg.cfg_half_period),
                .burst_i   (cfg.cfg_burst_len),
                .led_o     (led_out[gi]),
                .busy_o    (busy[gi]),
                .done_o    (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed scenarios plus random
// configuration traffic, compared every cycle against a tick-count model.
module tb_led_blink_ctrl;
    import led_blink_ctrl_pkg::*;

    localparam int          CH  = 4;
    localparam logic [23:0] TM  = 24'd3;
    localparam int          PW  = 8;
    localparam int          PERIOD = int'(TM) + 1;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [CH-1:0] led_out, busy, done;

    led_blink_ctrl_if #(.PER_W(PW)) cfg_if ();

    led_blink_ctrl #(
        .CH_NUM   (CH),
        .TICK_MAX (TM),
        .PER_W    (PW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cfg       (cfg_if),
        .led_out   (led_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A channel's led is a pure function of how many ticks it has seen since
    // its last load: the number of toggles is n / half, led is lit for an
    // even toggle count, and a burst of L cycles ends at toggle 2L-1.
    mode_t m_mode [CH];
    int    m_h    [CH];
    int    m_len  [CH];
    int    m_n    [CH];
    bit    m_done [CH];
    int    m_ec;            // clock edges seen since reset release

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = MODE_OFF;
            m_h[c]    = 1;
            m_len[c]  = 0;
            m_n[c]    = 0;
            m_done[c] = 1'b0;
        end
        m_ec = 0;
    endfunction

    function automatic void model_step();
        bit tick;
        bit xfer;
        tick = ((m_ec % PERIOD) == PERIOD - 1);
        xfer = cfg_if.cfg_valid && (m_ec >= 1);
        for (int c = 0; c < CH; c++) begin
            m_done[c] = 1'b0;
            if (xfer && (int'(cfg_if.cfg_ch) == c)) begin
                m_n[c]    = 0;
                m_h[c]    = (cfg_if.cfg_half_period == 0) ? 1 : int'(cfg_if.cfg_half_period);
                m_len[c]  = int'(cfg_if.cfg_burst_len);
                m_mode[c] = cfg_if.cfg_mode;
                if (cfg_if.cfg_mode == MODE_BURST && m_len[c] == 0) begin
                    m_mode[c] = MODE_OFF;
                    m_done[c] = 1'b1;
                end
            end else if (tick && (m_mode[c] == MODE_BLINK || m_mode[c] == MODE_BURST)) begin
                m_n[c]++;
                if (m_mode[c] == MODE_BURST && (m_n[c] / m_h[c]) >= 2 * m_len[c] - 1) begin
                    m_mode[c] = MODE_OFF;
                    m_done[c] = 1'b1;
                end
            end
        end
        m_ec++;
    endfunction

    function automatic logic [CH-1:0] exp_led();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) begin
            if (m_mode[c] == MODE_ON)
                v[c] = 1'b1;
            else if (m_mode[c] == MODE_BLINK || m_mode[c] == MODE_BURST)
                v[c] = (((m_n[c] / m_h[c]) % 2) == 0);
            else
                v[c] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++)
            v[c] = (m_mode[c] == MODE_BLINK || m_mode[c] == MODE_BURST);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_done();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++)
            v[c] = m_done[c];
        return v;
    endfunction

    // Model advances on each clock edge and clears on reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) model_reset();
            else            model_step();
        end
    end

    // Every falling edge: compare all outputs with the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            check("led_out",   32'(led_out),        32'(exp_led()));
            check("busy",      32'(busy),           32'(exp_busy()));
            check("done",      32'(done),           32'(exp_done()));
            check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ec >= 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int ch, input mode_t mode, input int half, input int len);
        cfg_if.cfg_valid       = 1'b1;
        cfg_if.cfg_ch          = CFG_CH_W'(ch);
        cfg_if.cfg_mode        = mode;
        cfg_if.cfg_half_period = PW'(half);
        cfg_if.cfg_burst_len   = BURST_W'(len);
        @(negedge sys_clk);
        cfg_if.cfg_valid       = 1'b0;
        $display("xfer ch=%0d mode=%0d half=%0d len=%0d t=%0t", ch, mode, half, len, $time);
    endtask

    initial begin
        int d;
        int pulses;
        int dones;
        int bad;
        bit prev;
        bit cur;
        bit found;

        cfg_if.cfg_valid       = 1'b0;
        cfg_if.cfg_ch          = '0;
        cfg_if.cfg_mode        = MODE_OFF;
        cfg_if.cfg_half_period = '0;
        cfg_if.cfg_burst_len   = '0;

        // Reset state.
        repeat (3) @(negedge sys_clk);
        check("rst_led",   32'(led_out), 32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        sys_rst_n = 1'b1;
        #1;
        check("ready_first_cycle", 32'(cfg_if.cfg_ready), 32'd0);
        @(negedge sys_clk);
        check("ready_after", 32'(cfg_if.cfg_ready), 32'd1);

        // BLINK on ch0, half-period 2 ticks.
        send(0, MODE_BLINK, 2, 0);
        check("blink_led_on", 32'(led_out[0]), 32'd1);
        check("blink_busy",   32'(busy[0]),    32'd1);
        d = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (!led_out[0]) begin
                d = i;
                break;
            end
        end
        checks++;
        if (d < 5 || d > 8) begin
            errors++;
            $display("FAIL blink_first_toggle: got %0d clocks expected 5..8", d);
        end

        // BURST of 3 on ch1, half-period 1 tick.
        send(1, MODE_BURST, 1, 3);
        check("burst_led_on", 32'(led_out[1]), 32'd1);
        pulses = 1;
        dones  = 0;
        prev   = led_out[1];
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            cur = led_out[1];
            if (cur && !prev) pulses++;
            if (done[1]) begin
                dones++;
                check("burst_done_on_fall", {30'd0, prev, cur}, 32'b10);
            end
            prev = cur;
        end
        check("burst_pulses",   32'(pulses),  32'd3);
        check("burst_dones",    32'(dones),   32'd1);
        check("burst_busy_end", 32'(busy[1]), 32'd0);

        // Empty burst on ch2, then a request to a nonexistent channel.
        send(2, MODE_BURST, 5, 0);
        check("empty_burst_done", 32'(done[2]),    32'd1);
        check("empty_burst_led",  32'(led_out[2]), 32'd0);
        @(negedge sys_clk);
        check("empty_burst_done_once", 32'(done[2]), 32'd0);
        send(7, MODE_ON, 1, 0);
        check("ch7_led",  32'(led_out[3:1]), 32'd0);
        check("ch7_busy", 32'(busy),         32'b0001);

        // ch3 blinking, then ON issued so the transfer lands on a tick edge.
        send(3, MODE_BLINK, 1, 0);
        repeat (6) @(negedge sys_clk);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((m_ec % PERIOD) == PERIOD - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check("tick_phase_found", 32'(found), 32'd1);
        send(3, MODE_ON, 0, 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (led_out[3] !== 1'b1 || busy[3] !== 1'b0 || done[3] !== 1'b0) bad++;
            @(negedge sys_clk);
        end
        check("on_over_tick_bad_cycles", 32'(bad), 32'd0);

        // Random configuration traffic.
        for (int i = 0; i < 600; i++) begin
            cfg_if.cfg_valid       = ($urandom_range(0, 11) == 0);
            cfg_if.cfg_ch          = CFG_CH_W'($urandom_range(0, 7));
            cfg_if.cfg_mode        = mode_t'($urandom_range(0, 3));
            cfg_if.cfg_half_period = PW'($urandom_range(0, 3));
            cfg_if.cfg_burst_len   = BURST_W'($urandom_range(0, 4));
            if (cfg_if.cfg_valid)
                $display("xfer ch=%0d mode=%0d half=%0d len=%0d t=%0t", cfg_if.cfg_ch,
                         cfg_if.cfg_mode, cfg_if.cfg_half_period, cfg_if.cfg_burst_len, $time);
            @(negedge sys_clk);
        end
        cfg_if.cfg_valid = 1'b0;

        // Reset asserted in the middle of a burst.
        send(1, MODE_BURST, 3, 5);
        repeat (10) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led",   32'(led_out), 32'd0);
        check("async_rst_busy",  32'(busy),    32'd0);
        check("async_rst_done",  32'(done),    32'd0);
        check("async_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (done != '0) dones++;
        end
        check("no_done_after_reset", 32'(dones), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
